// File: rtl/hella_cache_slave_bfm_if.sv
// HellaCache data-memory interface between the core-side master BFM and the
// behavioural slave memory model.
//
// Handshake rules:
//   - A request is accepted in the cycle where req_valid and req_ready are both 1.
//   - req_data, req_data_mask and req_kill belong to the request accepted in the
//     previous cycle.
//   - rsp_nack is raised in the second cycle after acceptance.
//   - rsp_valid is a one-cycle pulse. There is no rsp_ready: the master must
//     take the response in the cycle it is presented.
interface hella_cache_slave_bfm_if #(
    parameter int NUM_ADDR_BITS = 40,
    parameter int NUM_DATA_BITS = 64,
    parameter int NUM_TAG_BITS  = 7
);
    logic                       req_valid;
    logic                       req_ready;
    logic [NUM_ADDR_BITS-1:0]   req_addr;
    logic [NUM_TAG_BITS-1:0]    req_tag;
    logic [4:0]                 req_cmd;
    logic [2:0]                 req_typ;
    logic [NUM_DATA_BITS-1:0]   req_data;
    logic [NUM_DATA_BITS/8-1:0] req_data_mask;
    logic                       req_kill;
    logic                       rsp_nack;
    logic                       rsp_valid;
    logic [NUM_TAG_BITS-1:0]    rsp_tag;
    logic [2:0]                 rsp_typ;
    logic [NUM_DATA_BITS-1:0]   rsp_data;
    logic                       rsp_has_data;

    modport master (
        output req_valid, req_addr, req_tag, req_cmd, req_typ,
               req_data, req_data_mask, req_kill,
        input  req_ready, rsp_nack, rsp_valid, rsp_tag, rsp_typ,
               rsp_data, rsp_has_data
    );

    modport slave (
        input  req_valid, req_addr, req_tag, req_cmd, req_typ,
               req_data, req_data_mask, req_kill,
        output req_ready, rsp_nack, rsp_valid, rsp_tag, rsp_typ,
               rsp_data, rsp_has_data
    );
endinterface

// File: rtl/hella_cache_slave_bfm.sv
// Behavioural HellaCache slave. It answers core-side requests from an internal
// word array.
//
// Pipeline:
//   - s0: request accepted.
//   - s1: store data/mask/kill captured.
//   - s2: nack decision and memory access.
//   - The response queue then releases in-order responses once each has aged
//     LATENCY cycles, counting the s2 cycle.
//
// Optional build macro HELLA_CACHE_SLAVE_BFM_BACKPRESSURE_EN: a 16-bit LFSR
// throttles req_ready (bit 0) and injects random s2 nacks (bit 1).
module hella_cache_slave_bfm #(
    parameter int NUM_ADDR_BITS = 40,
    parameter int NUM_DATA_BITS = 64,
    parameter int NUM_TAG_BITS  = 7,
    parameter int MEM_WORDS     = 1024,
    parameter int LATENCY       = 2,
    parameter int RSP_DEPTH     = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    hella_cache_slave_bfm_if.slave bus
);
    localparam int         IDX_W  = $clog2(MEM_WORDS);
    localparam int         ADDR_HI = IDX_W + 2;          // highest address bit that matters
    localparam int         PTR_W  = $clog2(RSP_DEPTH);
    localparam int         CNT_W  = PTR_W + 1;
    localparam int         AGE_W  = $clog2(LATENCY + 1);
    localparam int         MASK_W = NUM_DATA_BITS / 8;
    localparam logic [4:0] M_XWR  = 5'd1;

    // ------------------------------------------------------------------
    // Acceptance and optional backpressure
    // ------------------------------------------------------------------
    logic ready_q;
    logic accept_ok;
    logic bp_nack;
    logic accept;

    // req_ready drops during reset and comes back one cycle after release
    always_ff @(posedge clock) begin
        if (reset) ready_q <= 1'b0;
        else       ready_q <= 1'b1;
    end

`ifdef HELLA_CACHE_SLAVE_BFM_BACKPRESSURE_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11 map to bits 15,13,12,10
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Free-running LFSR, reseeded on reset
    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end

    assign accept_ok = ready_q & lfsr_q[0];
    assign bp_nack   = lfsr_q[1];
`else
    assign accept_ok = ready_q;
    assign bp_nack   = 1'b0;
`endif

    assign bus.req_ready = accept_ok;
    assign accept        = bus.req_valid & accept_ok;

    // Upper address bits above the array index are ignored (addresses wrap)
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[NUM_ADDR_BITS-1:ADDR_HI+1];

    // ------------------------------------------------------------------
    // s1: request fields of the request accepted last cycle
    // ------------------------------------------------------------------
    logic                    s1_valid;
    logic [ADDR_HI:0]        s1_addr;
    logic [NUM_TAG_BITS-1:0] s1_tag;
    logic                    s1_store;
    logic [2:0]              s1_typ;

    // Capture the request on acceptance; reset drops anything in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_tag   <= '0;
            s1_store <= 1'b0;
            s1_typ   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_addr  <= bus.req_addr[ADDR_HI:0];
                s1_tag   <= bus.req_tag;
                s1_store <= (bus.req_cmd == M_XWR);
                s1_typ   <= bus.req_typ;
            end
        end
    end

    // ------------------------------------------------------------------
    // s2: request plus store data; a killed request never reaches s2
    // ------------------------------------------------------------------
    logic                     s2_valid;
    logic [ADDR_HI:0]         s2_addr;
    logic [NUM_TAG_BITS-1:0]  s2_tag;
    logic                     s2_store;
    logic [2:0]               s2_typ;
    logic [NUM_DATA_BITS-1:0] s2_data;
    logic [MASK_W-1:0]        s2_mask;

    // Advance s1 into s2, sampling store data/mask and the s1 kill
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_tag   <= '0;
            s2_store <= 1'b0;
            s2_typ   <= '0;
            s2_data  <= '0;
            s2_mask  <= '0;
        end else begin
            s2_valid <= s1_valid & ~bus.req_kill;
            if (s1_valid) begin
                s2_addr  <= s1_addr;
                s2_tag   <= s1_tag;
                s2_store <= s1_store;
                s2_typ   <= s1_typ;
                s2_data  <= bus.req_data;
                s2_mask  <= bus.req_data_mask;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory array and s2 access
    // ------------------------------------------------------------------
    logic [NUM_DATA_BITS-1:0] mem [MEM_WORDS];
    logic [IDX_W-1:0]         s2_idx;
    logic [NUM_DATA_BITS-1:0] rd_word;
    logic [NUM_DATA_BITS-1:0] ld_shift;
    logic [NUM_DATA_BITS-1:0] ld_data;
    logic [CNT_W-1:0]         count_q;
    logic                     q_full;
    logic                     s2_nack;
    logic                     s2_fire;

    assign s2_idx  = s2_addr[ADDR_HI:3];
    assign rd_word = mem[s2_idx];

    // Occupancy is checked before this cycle's pop, so a full queue nacks
    // even when the head leaves in the same cycle
    assign q_full       = (count_q == CNT_W'(RSP_DEPTH));
    assign s2_nack      = s2_valid & (q_full | bp_nack);
    assign s2_fire      = s2_valid & ~s2_nack;
    assign bus.rsp_nack = s2_nack;

    // Load path: shift the word down by the byte offset, truncate to the
    // access size, then sign- or zero-extend
    always_comb begin
        ld_shift = rd_word >> {s2_addr[2:0], 3'b000};
        ld_data  = ld_shift;
        case (s2_typ[1:0])
            2'd0: ld_data = s2_typ[2] ?
                            {{(NUM_DATA_BITS-8){1'b0}}, ld_shift[7:0]} :
                            {{(NUM_DATA_BITS-8){ld_shift[7]}}, ld_shift[7:0]};
            2'd1: ld_data = s2_typ[2] ?
                            {{(NUM_DATA_BITS-16){1'b0}}, ld_shift[15:0]} :
                            {{(NUM_DATA_BITS-16){ld_shift[15]}}, ld_shift[15:0]};
            2'd2: ld_data = s2_typ[2] ?
                            {{(NUM_DATA_BITS-32){1'b0}}, ld_shift[31:0]} :
                            {{(NUM_DATA_BITS-32){ld_shift[31]}}, ld_shift[31:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // Byte-lane store into the array; contents deliberately survive reset
    always_ff @(posedge clock) begin
        if (!reset && s2_fire && s2_store) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (s2_mask[b]) mem[s2_idx][b*8 +: 8] <= s2_data[b*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response queue with per-entry age
    // ------------------------------------------------------------------
    logic [NUM_TAG_BITS-1:0]  q_tag      [RSP_DEPTH];
    logic [2:0]               q_typ      [RSP_DEPTH];
    logic [NUM_DATA_BITS-1:0] q_data     [RSP_DEPTH];
    logic                     q_has_data [RSP_DEPTH];
    logic [AGE_W-1:0]         q_age      [RSP_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic                     push;
    logic                     pop;
    logic                     head_ok;

    // The s2 cycle counts as age 0, so an entry lands in the queue with
    // age 1 and the head leaves once its age reaches LATENCY
    assign head_ok = (count_q != '0) && (q_age[rd_ptr_q] >= AGE_W'(LATENCY));
    assign push    = s2_fire;
    assign pop     = head_ok;

    // Queue control: pointers, occupancy and saturating ages
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) q_age[i] <= '0;
        end else begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                if (q_age[i] != AGE_W'(LATENCY)) q_age[i] <= q_age[i] + 1'b1;
            end
            if (push) begin
                q_age[wr_ptr_q] <= AGE_W'(1);
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Queue payload; only meaningful behind the occupancy count
    always_ff @(posedge clock) begin
        if (push) begin
            q_tag[wr_ptr_q]      <= s2_tag;
            q_typ[wr_ptr_q]      <= s2_typ;
            q_data[wr_ptr_q]     <= s2_store ? '0 : ld_data;
            q_has_data[wr_ptr_q] <= ~s2_store;
        end
    end

    // Present the head for exactly the cycle it is popped
    always_comb begin
        bus.rsp_valid    = 1'b0;
        bus.rsp_tag      = '0;
        bus.rsp_typ      = '0;
        bus.rsp_data     = '0;
        bus.rsp_has_data = 1'b0;
        if (head_ok) begin
            bus.rsp_valid    = 1'b1;
            bus.rsp_tag      = q_tag[rd_ptr_q];
            bus.rsp_typ      = q_typ[rd_ptr_q];
            bus.rsp_data     = q_data[rd_ptr_q];
            bus.rsp_has_data = q_has_data[rd_ptr_q];
        end
    end
endmodule

// File: tb/tb_hella_cache_slave_bfm.sv
// Bench for hella_cache_slave_bfm.
//   - The driver issues one request per cycle.
//   - A reference model resolves each request when its s2 cycle is known.
//     It applies the store/load rules to a word array.
//   - The model computes when the response must appear. The rule is
//     max(s2 + LATENCY, previous response + 1).
//   - Queue occupancy is the number of responses not yet emitted.
//   - The monitor checks req_ready, rsp_nack and every response each cycle.
// LATENCY 8 / RSP_DEPTH 4 is used so the queue can actually fill.
module tb_hella_cache_slave_bfm;
    localparam int AW    = 40;
    localparam int DW    = 64;
    localparam int TW    = 7;
    localparam int MW    = 1024;
    localparam int LAT   = 8;
    localparam int DEPTH = 4;
    localparam int MAXC  = 4096;
    localparam int RW    = TW + 3 + 1 + DW;

    typedef struct {
        bit            store;
        logic [AW-1:0] addr;
        logic [2:0]    typ;
        logic [TW-1:0] tag;
    } req_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    hella_cache_slave_bfm_if #(.NUM_ADDR_BITS(AW), .NUM_DATA_BITS(DW), .NUM_TAG_BITS(TW)) bus ();

    hella_cache_slave_bfm #(
        .NUM_ADDR_BITS(AW), .NUM_DATA_BITS(DW), .NUM_TAG_BITS(TW),
        .MEM_WORDS(MW), .LATENCY(LAT), .RSP_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- reference model state ----------------
    logic [RW-1:0] exp_q[$];          // expected {tag, typ, has_data, data}
    int            exp_t[$];          // cycle each expected response appears
    bit            exp_ready [MAXC];
    bit            exp_nack  [MAXC];
    logic [DW-1:0] mem_m [MW];
    req_t          s1_req;
    bit            s1_pend = 1'b0;
    logic [DW-1:0] s1_data_hold = '0;
    logic [7:0]    s1_mask_hold = '0;
    bit            s1_kill_hold = 1'b0;
    int            last_emit = 0;
    logic [TW-1:0] tag_ctr = '0;

    function automatic logic [DW-1:0] load_value(logic [DW-1:0] word, logic [2:0] off, logic [2:0] typ);
        logic [DW-1:0] sh;
        logic [DW-1:0] m;
        logic [DW-1:0] v;
        int nb;
        sh = word >> (8 * int'(off));
        nb = 1 << int'(typ[1:0]);
        if (nb == 8) return sh;
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = sh & m;
        if (!typ[2] && sh[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    // Resolve the request sitting in s1 whose s2 cycle is s2c
    function automatic void resolve(int s2c, logic [DW-1:0] data, logic [7:0] mask, bit kill);
        int occ;
        int idx;
        int emit;
        logic [DW-1:0] rdata;
        if (kill) return;
        occ = 0;
        foreach (exp_t[i]) if (exp_t[i] >= s2c) occ++;
        if (occ >= DEPTH) begin
            exp_nack[s2c] = 1'b1;
            return;
        end
        idx = int'(s1_req.addr[12:3]);
        if (s1_req.store) begin
            for (int b = 0; b < 8; b++) if (mask[b]) mem_m[idx][b*8 +: 8] = data[b*8 +: 8];
            rdata = '0;
        end else begin
            rdata = load_value(mem_m[idx], s1_req.addr[2:0], s1_req.typ);
        end
        emit = (s2c + LAT > last_emit + 1) ? s2c + LAT : last_emit + 1;
        last_emit = emit;
        exp_q.push_back({s1_req.tag, s1_req.typ, ~s1_req.store, rdata});
        exp_t.push_back(emit);
    endfunction

    // ---------------- driver tasks ----------------
    // One clock cycle: drives the new request plus the s1 data/mask/kill of
    // the previous one; data/mask/kill passed here belong to this request.
    task automatic drive_cycle(input bit rst, input bit v, input logic [4:0] cmd,
                               input logic [AW-1:0] addr, input logic [2:0] typ,
                               input logic [DW-1:0] data, input logic [7:0] mask, input bit kill);
        int c;
        @(negedge clock);
        c = cyc;
        if (c + 1 >= MAXC) begin
            $display("FAIL cycle_budget: cycle %0d reached limit %0d", c, MAXC);
            n_errors++;
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $fatal(1, "cycle budget exhausted");
        end
        reset             = rst;
        bus.req_valid     = v && !rst;
        bus.req_cmd       = cmd;
        bus.req_addr      = addr;
        bus.req_typ       = typ;
        bus.req_tag       = tag_ctr;
        bus.req_data      = s1_data_hold;
        bus.req_data_mask = s1_mask_hold;
        bus.req_kill      = s1_kill_hold;
        exp_ready[c+1]    = !rst;
        if (rst) begin
            s1_pend = 1'b0;
            while (exp_t.size() > 0 && exp_t[$] > c) begin
                void'(exp_t.pop_back());
                void'(exp_q.pop_back());
            end
            last_emit = c;
        end else begin
            if (s1_pend) resolve(c + 1, s1_data_hold, s1_mask_hold, s1_kill_hold);
            s1_pend = v && exp_ready[c];
            if (s1_pend) s1_req = '{store: (cmd == 5'd1), addr: addr, typ: typ, tag: tag_ctr};
        end
        s1_data_hold = data;
        s1_mask_hold = mask;
        s1_kill_hold = kill;
        tag_ctr++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 5'd0, '0, 3'd0, '0, 8'h00, 1'b0);
    endtask

    task automatic st(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [7:0] mask, input bit kill);
        drive_cycle(1'b0, 1'b1, 5'd1, addr, 3'd3, data, mask, kill);
    endtask

    task automatic ld(input logic [AW-1:0] addr, input logic [2:0] typ);
        drive_cycle(1'b0, 1'b1, 5'd0, addr, typ, '0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || s1_pend) && n < 200) begin
            idle(1);
            n++;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
            n_errors++;
        end
        idle(2);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        int c;
        logic [RW-1:0] got;
        logic [RW-1:0] e;
        int t;
        c = cyc;
        if (c >= 1 && c < MAXC) begin
            n_checks++;
            if (bus.req_ready !== exp_ready[c]) begin
                $display("FAIL req_ready @%0d: got %b expected %b", c, bus.req_ready, exp_ready[c]);
                n_errors++;
            end
            n_checks++;
            if (bus.rsp_nack !== exp_nack[c]) begin
                $display("FAIL rsp_nack @%0d: got %b expected %b", c, bus.rsp_nack, exp_nack[c]);
                n_errors++;
            end
            if (bus.rsp_valid === 1'b1) begin
                n_checks++;
                got = {bus.rsp_tag, bus.rsp_typ, bus.rsp_has_data, bus.rsp_data};
                if (exp_q.size() == 0) begin
                    $display("FAIL rsp_unexpected @%0d: got %h expected no response", c, got);
                    n_errors++;
                end else begin
                    e = exp_q.pop_front();
                    t = exp_t.pop_front();
                    if (got !== e || t != c) begin
                        $display("FAIL rsp @%0d: got %h expected %h at cycle %0d", c, got, e, t);
                        n_errors++;
                    end
                end
            end else if (bus.rsp_valid !== 1'b0) begin
                n_checks++;
                $display("FAIL rsp_valid @%0d: got %b expected 0/1", c, bus.rsp_valid);
                n_errors++;
            end else if (exp_t.size() > 0 && exp_t[0] <= c) begin
                n_checks++;
                $display("FAIL rsp_missing @%0d: got no response expected %h", c, exp_q[0]);
                n_errors++;
                void'(exp_t.pop_front());
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] a;
        logic [4:0]    cmd;
        int            r;

        bus.req_valid     = 1'b0;
        bus.req_addr      = '0;
        bus.req_tag       = '0;
        bus.req_cmd       = '0;
        bus.req_typ       = '0;
        bus.req_data      = '0;
        bus.req_data_mask = '0;
        bus.req_kill      = 1'b0;

        // reset
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 5'd0, '0, 3'd0, '0, 8'h00, 1'b0);
        idle(2);

        // initialise words 0..31 at a rate the queue never nacks
        for (int w = 0; w < 32; w++) begin
            st(AW'(w * 8), {$urandom(), $urandom()}, 8'hFF, 1'b0);
            idle(3);
        end
        drain();

        // store then load, same address
        st(40'h10, 64'h1122334455667788, 8'hFF, 1'b0);
        ld(40'h10, 3'd3);
        drain();

        // sign / zero extension of a byte at offset 1
        st(40'h18, 64'h00000000000080FF, 8'hFF, 1'b0);
        ld(40'h19, 3'd0);
        ld(40'h19, 3'd4);
        drain();

        // killed store leaves memory untouched and gives no response
        st(40'h20, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1);
        idle(3);
        ld(40'h20, 3'd3);
        drain();

        // address wrap: 0x2000 maps to word 0
        st(40'h2000, 64'h0F1E2D3C4B5A6978, 8'hFF, 1'b0);
        ld(40'h0, 3'd3);
        ld(40'hAB_0000_0000, 3'd3);
        drain();

        // partial mask store and misaligned loads
        st(40'h28, 64'hA1B2C3D4E5F60718, 8'h5A, 1'b0);
        ld(40'h28, 3'd3);
        ld(40'h2D, 3'd3);
        drain();
        ld(40'h2E, 3'd1);
        ld(40'h2B, 3'd6);
        drain();

        // queue full: six back-to-back loads, the last two are nacked
        for (int i = 0; i < 6; i++) ld(AW'(8 * i), 3'd3);
        drain();

        // reset one cycle after the last acceptance, memory survives
        st(40'h30, 64'h5555AAAA3333CCCC, 8'hFF, 1'b0);
        drain();
        ld(40'h30, 3'd3);
        ld(40'h38, 3'd3);
        ld(40'h30, 3'd2);
        drive_cycle(1'b1, 1'b0, 5'd0, '0, 3'd0, '0, 8'h00, 1'b0);
        drive_cycle(1'b1, 1'b0, 5'd0, '0, 3'd0, '0, 8'h00, 1'b0);
        idle(1);
        ld(40'h30, 3'd3);
        drain();

        // randomized traffic over words 0..31 with random upper address bits
        for (int i = 0; i < 700; i++) begin
            a = AW'({$urandom(), $urandom()});
            a[12:8] = 5'd0;
            r = int'($urandom_range(0, 9));
            if (r < 4)       cmd = 5'd1;
            else if (r == 9) cmd = 5'($urandom_range(2, 31));
            else             cmd = 5'd0;
            drive_cycle(1'b0, ($urandom_range(0, 2) == 0), cmd, a, 3'($urandom_range(0, 7)),
                        {$urandom(), $urandom()}, 8'($urandom_range(0, 255)),
                        ($urandom_range(0, 4) == 0));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
